// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch-to-decode pipeline register: NOP encoding,
// zero-register index and instruction field positions.
package if_id_stage_pkg;

    localparam logic [31:0] NOP_ENC = 32'hD503201F;
    localparam int          REG_W   = 5;
    localparam logic [4:0]  XZR     = 5'd31;
    localparam int          RN_LSB  = 5;
    localparam int          RM_LSB  = 16;

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_stage.sv
// Fetch-to-decode pipeline register with load-use hazard detection, branch
// flush, and saturating stall/flush counters for performance debug.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 64,
    parameter int                 CNT_W     = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_ENC
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instr_if,
    input  logic [PC_W-1:0]    pc_if,
    input  logic               valid_if,
    input  logic               uses_rm_dec,
    input  logic               MemToReg_ex,
    input  logic               RegWrite_ex,
    input  logic [4:0]         rd_ex,
    input  logic               branch_taken_ex,
    output logic [INSTR_W-1:0] instr_dec,
    output logic [PC_W-1:0]    pc_dec,
    output logic               valid_dec,
    output logic               stall_if,
    output logic               bubble_dec,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    logic [REG_W-1:0] rn;
    logic [REG_W-1:0] rm;
    logic             hazard;
    logic             flush;

    assign rn = instr_q[RN_LSB +: REG_W];
    assign rm = instr_q[RM_LSB +: REG_W];

    // A load writing XZR produces nothing a consumer could depend on.
    assign hazard = valid_q & MemToReg_ex & RegWrite_ex & (rd_ex != XZR) &
                    ((rd_ex == rn) | (uses_rm_dec & (rd_ex == rm)));
    assign flush  = branch_taken_ex;

    assign stall_if   = hazard & ~flush;
    assign bubble_dec = ~valid_q | hazard | flush;

    // Flush wins over a stall: the wrong-path instruction is dropped, so
    // there is nothing left to hold. pc is kept only for debug visibility.
    always_comb begin
        instr_d = instr_if;
        pc_d    = pc_if;
        valid_d = valid_if;
        if (flush) begin
            instr_d = NOP_INSTR;
            pc_d    = pc_q;
            valid_d = 1'b0;
        end else if (hazard) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_dec = instr_q;
    assign pc_dec    = pc_q;
    assign valid_dec = valid_q;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_if),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
Fetch-to-decode pipeline register with load-use hazard detection and branch flush for the pipelined datapath. It captures the fetched instruction and PC, and presents them to the decoder. It tells fetch when to hold the PC, and tells the decode-to-execute control register when to load a bubble (all control signals zero). It also keeps saturating stall and flush counters for performance debug.

Parameters:
INSTR_W, 32, instruction width
PC_W, 64, program counter width
CNT_W, 16, width of each performance counter
NOP_INSTR, 32'hD503201F, encoding loaded into instr_dec on reset and flush

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
instr_if  input  INSTR_W  instruction from fetch
pc_if  input  PC_W  PC of instr_if
valid_if  input  1  instr_if is a real instruction
uses_rm_dec  input  1  decoder: instruction in decode reads Rm (combinational from instr_dec)
MemToReg_ex  input  1  execute-stage instruction is a load
RegWrite_ex  input  1  execute-stage instruction writes a register
rd_ex  input  5  execute-stage destination register
branch_taken_ex  input  1  branch resolved taken in execute
instr_dec  output  INSTR_W  registered instruction to decoder
pc_dec  output  PC_W  registered PC
valid_dec  output  1  registered valid
stall_if  output  1  hold PC and fetch this cycle
bubble_dec  output  1  force zero controls into the decode-to-execute register
stall_count  output  CNT_W  saturating load-use stall count
flush_count  output  CNT_W  saturating flush count

Behaviour:
- Reset (reset=0, async): instr_dec=NOP_INSTR, pc_dec=0, valid_dec=0, both counters=0.
  - Combinational outputs follow from these values: stall_if=0, bubble_dec=1.
- Field extraction from instr_dec: rn=[9:5], rm=[20:16]. Register 31 (XZR) never causes a hazard.
- hazard (combinational) = valid_dec & MemToReg_ex & RegWrite_ex & (rd_ex!=31) & ((rd_ex==rn) | (uses_rm_dec & rd_ex==rm)).
- flush = branch_taken_ex. flush has priority over hazard.
- stall_if = hazard & ~flush.
- bubble_dec = ~valid_dec | hazard | flush.
- Register update each rising edge:
  - flush: instr_dec<=NOP_INSTR, valid_dec<=0, pc_dec unchanged. The instruction on instr_if is discarded.
  - else hazard: hold instr_dec, pc_dec, valid_dec.
  - else: instr_dec<=instr_if, pc_dec<=pc_if, valid_dec<=valid_if.
- Stall duration: a load-use stall lasts exactly one cycle. The bubble removes the load from execute, so hazard deasserts on the next cycle without extra state.
- Back-to-back hazards each count separately.
- Counters:
  - stall_count increments in every cycle where stall_if=1.
  - flush_count increments in every cycle where flush=1.
  - Both saturate at all-ones and never wrap.
- Latency: one cycle from instr_if to instr_dec when not stalled or flushed.
- Reset asserted mid-stall or mid-flush: the stage returns to reset values immediately.
  - The first edge after reset release loads instr_if normally.

Decomposition:
- Shared package holds:
  - NOP encoding constant
  - XZR index (31)
  - Rn/Rm field LSB positions (5, 16) and register-address width (5)
- One natural sub-module: sat_counter (parameter CNT_W; inputs clk, reset, inc; output count). Instantiated twice.

Test Plan:
- Reset then release, feed instr_if=32'h8B020020, pc_if=0x40, valid_if=1 -> next edge instr_dec=32'h8B020020, pc_dec=0x40, valid_dec=1, bubble_dec=0.
- instr_dec reads Rn=1; execute holds load (MemToReg_ex=1, RegWrite_ex=1, rd_ex=1) -> stall_if=1 and bubble_dec=1 for one cycle, instr_dec held, stall_count=1. Next cycle with execute controls zero -> stall_if=0.
- Same as above but rd_ex=31, or rd_ex matches Rm with uses_rm_dec=0 -> no stall, stall_count unchanged.
- branch_taken_ex=1 while a hazard condition is also true -> stall_if=0, bubble_dec=1. Next edge instr_dec=NOP_INSTR, valid_dec=0, flush_count=1, stall_count unchanged.
- Hold hazard every cycle for 2^CNT_W+5 cycles (CNT_W=4 in bench) -> stall_count saturates at 15.
- Assert reset asynchronously mid-stall (between edges) -> all outputs at reset values immediately, without waiting for a clock edge.
